// File: rtl/fc_layer_lanes.sv
// Fully connected layer y = b + W^T x, fixed-point signed, LANES neurons per pass.
// Each pass: BIAS load, IN_SIZE MAC cycles, STORE with rounding/saturation/ReLU.
module fc_lane #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bias_ld,
  input  logic                     mac_en,
  input  logic                     relu,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] res,
  output logic                     sat
);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC-1);
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (DATA_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) << (DATA_W-1));

  logic signed [ACC_W-1:0]    acc, sum, rnd;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = x * w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (bias_ld) acc <= ACC_W'(b) <<< FRAC;
    else if (mac_en)  acc <= acc + ACC_W'(prod);
  end

  // Round half up, saturate, then ReLU (saturation is flagged before ReLU clamps)
  always_comb begin
    sum = acc + HALF;
    rnd = sum >>> FRAC;
    sat = 1'b0;
    res = rnd[DATA_W-1:0];
    if (rnd > MAXV) begin
      res = MAXV[DATA_W-1:0];
      sat = 1'b1;
    end else if (rnd < MINV) begin
      res = MINV[DATA_W-1:0];
      sat = 1'b1;
    end
    if (relu && res[DATA_W-1]) res = '0;
  end
endmodule

module fc_layer_lanes #(
  parameter int IN_SIZE  = 100,
  parameter int OUT_SIZE = 10,
  parameter int DATA_W   = 16,
  parameter int FRAC     = 8,
  parameter int LANES    = 2,
  parameter int ACC_W    = 2*DATA_W + $clog2(IN_SIZE) + 1,
  parameter int IDX_W    = $clog2((IN_SIZE > OUT_SIZE) ? IN_SIZE : OUT_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic                         wr_sel_i,
  input  logic [IDX_W-1:0]             wr_in_idx_i,
  input  logic [IDX_W-1:0]             wr_out_idx_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  output logic                         wr_err_o,
  input  logic                         relu_en_i,
  input  logic                         start_valid_i,
  output logic                         start_ready_o,
  input  logic [IN_SIZE*DATA_W-1:0]    x_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [OUT_SIZE*DATA_W-1:0]   y_o,
  output logic                         sat_o,
  output logic                         busy_o
);
  localparam int GROUPS = (OUT_SIZE + LANES - 1) / LANES;
  localparam int IN_AW  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int OUT_AW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(IN_SIZE - 1);
  localparam logic [IDX_W-1:0] G_LAST = IDX_W'(GROUPS - 1);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, STORE, DONE} state_t;

  state_t                            state;
  logic signed [DATA_W-1:0]          w_mem [IN_SIZE][OUT_SIZE];
  logic signed [DATA_W-1:0]          b_mem [OUT_SIZE];
  logic [IN_SIZE-1:0][DATA_W-1:0]    x_buf;
  logic [OUT_SIZE-1:0][DATA_W-1:0]   y_q;
  logic [IDX_W-1:0]                  k, g;
  logic                              relu_q;
  logic signed [DATA_W-1:0]          x_cur;
  logic [LANES-1:0][DATA_W-1:0]      lane_res;
  logic [LANES-1:0][OUT_AW-1:0]      lane_idx;
  logic [LANES-1:0]                  lane_sat, lane_ok;
  logic                              start_acc, wr_bad;

  assign y_o       = y_q;
  assign x_cur     = x_buf[IN_AW'(k)];
  assign start_acc = start_valid_i & start_ready_o;
  // Start wins over a same-edge write; bias writes ignore the row index
  assign wr_bad    = (state != IDLE) | start_acc
                   | (!wr_sel_i && int'(wr_in_idx_i) >= IN_SIZE)
                   | (int'(wr_out_idx_i) >= OUT_SIZE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int                       nidx;
    logic                     ok;
    logic signed [DATA_W-1:0] w_sel, b_sel;
    logic signed [DATA_W-1:0] res;

    always_comb begin
      nidx  = int'(g) * LANES + l;
      ok    = nidx < OUT_SIZE;
      w_sel = ok ? w_mem[IN_AW'(k)][OUT_AW'(nidx)] : '0;
      b_sel = ok ? b_mem[OUT_AW'(nidx)] : '0;
    end

    assign lane_ok[l]  = ok;
    assign lane_idx[l] = OUT_AW'(nidx);
    assign lane_res[l] = res;

    fc_lane #(.DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .bias_ld (state == BIAS),
      .mac_en  (state == MAC),
      .relu    (relu_q),
      .x       (x_cur),
      .w       (w_sel),
      .b       (b_sel),
      .res     (res),
      .sat     (lane_sat[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_ready_o <= 1'b1;
      busy_o        <= 1'b0;
      out_valid_o   <= 1'b0;
      sat_o         <= 1'b0;
      wr_err_o      <= 1'b0;
      relu_q        <= 1'b0;
      k             <= '0;
      g             <= '0;
      x_buf         <= '0;
      y_q           <= '0;
      for (int i = 0; i < IN_SIZE; i++)
        for (int j = 0; j < OUT_SIZE; j++) w_mem[i][j] <= '0;
      for (int j = 0; j < OUT_SIZE; j++) b_mem[j] <= '0;
    end else begin
      wr_err_o <= wr_en_i & wr_bad;
      case (state)
        IDLE: begin
          if (start_acc) begin
            x_buf         <= x_i;
            relu_q        <= relu_en_i;
            sat_o         <= 1'b0;
            g             <= '0;
            state         <= BIAS;
            start_ready_o <= 1'b0;
            busy_o        <= 1'b1;
          end else if (wr_en_i && !wr_bad) begin
            if (wr_sel_i) b_mem[OUT_AW'(wr_out_idx_i)] <= wr_data_i;
            else          w_mem[IN_AW'(wr_in_idx_i)][OUT_AW'(wr_out_idx_i)] <= wr_data_i;
          end
        end
        BIAS: begin
          k     <= '0;
          state <= MAC;
        end
        MAC: begin
          if (k == K_LAST) state <= STORE;
          else             k <= k + IDX_W'(1);
        end
        STORE: begin
          for (int l = 0; l < LANES; l++)
            if (lane_ok[l]) y_q[lane_idx[l]] <= lane_res[l];
          sat_o <= sat_o | (|(lane_sat & lane_ok));
          g     <= g + IDX_W'(1);
          if (g == G_LAST) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
          end else begin
            state <= BIAS;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o   <= 1'b0;
            state         <= IDLE;
            start_ready_o <= 1'b1;
            busy_o        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_lanes.sv
// Directed bench for fc_layer_lanes at default parameters (100 in, 10 out, 2 lanes).
module tb_fc_layer_lanes;
  localparam int IN = 100, OUT = 10, DW = 16, IDXW = 7, LAT = 510;

  logic              clk = 1'b0, rst_n;
  logic              wr_en, wr_sel, wr_err, relu_en, start_valid, start_ready;
  logic [IDXW-1:0]   wr_in_idx, wr_out_idx;
  logic [DW-1:0]     wr_data;
  logic [IN*DW-1:0]  x;
  logic              out_valid, out_ready, sat, busy;
  logic [OUT*DW-1:0] y;

  int checks = 0, failures = 0, cyc = 0, err_cnt = 0, t_acc = 0, e0;

  fc_layer_lanes dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
    .wr_in_idx_i(wr_in_idx), .wr_out_idx_i(wr_out_idx), .wr_data_i(wr_data),
    .wr_err_o(wr_err), .relu_en_i(relu_en), .start_valid_i(start_valid),
    .start_ready_o(start_ready), .x_i(x), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .y_o(y), .sat_o(sat), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (wr_err) err_cnt <= err_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] yv(input int j);
    return y[j*DW +: DW];
  endfunction

  task automatic wr(input bit sel, input int i, input int j, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_in_idx = IDXW'(i); wr_out_idx = IDXW'(j); wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic fill_w(input logic [DW-1:0] d);
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < OUT; j++) wr(1'b0, i, j, d);
  endtask

  task automatic set_x(input logic [DW-1:0] d);
    for (int k = 0; k < IN; k++) x[k*DW +: DW] = d;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; tick; tick; rst_n = 1'b1; tick;
  endtask

  task automatic start_run(input bit relu);
    relu_en = relu; start_valid = 1'b1;
    tick;
    start_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input string tag);
    while (!out_valid && (cyc - t_acc) < 3000) tick;
    chk(tag, 64'(cyc - t_acc), 64'(LAT));
  endtask

  task automatic handshake;
    out_ready = 1'b1; tick; out_ready = 1'b0;
    chk("hs_valid", 64'(out_valid), 64'd0);
    chk("hs_ready", 64'(start_ready), 64'd1);
  endtask

  task automatic chk_y_all(input string tag, input logic [DW-1:0] e);
    for (int j = 0; j < OUT; j++) chk($sformatf("%s[%0d]", tag, j), 64'(yv(j)), 64'(e));
  endtask

  initial begin
    wr_en = 0; wr_sel = 0; wr_in_idx = '0; wr_out_idx = '0; wr_data = '0;
    relu_en = 0; start_valid = 0; out_ready = 0; x = '0; rst_n = 1'b0;
    do_reset;

    chk("rst_ready", 64'(start_ready), 64'd1);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_y",     64'(|y), 64'd0);
    chk("rst_sat",   64'(sat), 64'd0);
    chk("rst_err",   64'(wr_err), 64'd0);

    // 1: W=0, b[j]=j.0
    e0 = err_cnt;
    for (int j = 0; j < OUT; j++) wr(1'b1, 0, j, DW'(j*256));
    set_x(16'd256);
    start_run(1'b0);
    chk("t1_busy",  64'(busy), 64'd1);
    chk("t1_ready", 64'(start_ready), 64'd0);
    wait_done("t1_lat");
    for (int j = 0; j < OUT; j++) chk($sformatf("t1_y[%0d]", j), 64'(yv(j)), 64'(j*256));
    chk("t1_sat", 64'(sat), 64'd0);
    handshake;
    chk("t1_yhold", 64'(yv(3)), 64'd768);
    tick;
    chk("t1_noerr", 64'(err_cnt), 64'(e0));

    // 2: x=1.0, W=0.5, b=0 -> 50.0
    for (int j = 0; j < OUT; j++) wr(1'b1, 0, j, 16'd0);
    fill_w(16'd128);
    start_run(1'b0);
    wait_done("t2_lat");
    chk_y_all("t2_y", 16'd12800);
    chk("t2_sat", 64'(sat), 64'd0);
    handshake;

    // 3: positive and negative saturation, ReLU
    fill_w(16'h7FFF);
    set_x(16'h7FFF);
    start_run(1'b0);
    wait_done("t3a_lat");
    chk_y_all("t3a_y", 16'h7FFF);
    chk("t3a_sat", 64'(sat), 64'd1);
    handshake;
    fill_w(16'h8001);
    start_run(1'b1);
    wait_done("t3b_lat");
    chk_y_all("t3b_y", 16'h0000);
    chk("t3b_sat", 64'(sat), 64'd1);
    handshake;

    // 4: rounding at exactly half an LSB
    do_reset;
    set_x(16'd0);
    x[DW-1:0] = 16'd1;
    wr(1'b0, 0, 0, 16'd128);
    start_run(1'b0);
    wait_done("t4a_lat");
    chk("t4a_y0", 64'(yv(0)), 64'd1);
    chk("t4a_y1", 64'(yv(1)), 64'd0);
    chk("t4a_sat", 64'(sat), 64'd0);
    handshake;
    x[DW-1:0] = 16'hFFFF;
    start_run(1'b0);
    wait_done("t4b_lat");
    chk("t4b_y0", 64'(yv(0)), 64'd0);
    handshake;

    // 5: rejected writes, ignored start, x isolation, DONE hold
    x[DW-1:0] = 16'd1;
    start_run(1'b0);
    repeat (5) tick;
    wr(1'b0, 0, 0, 16'h7FFF);
    chk("t5_err_busy", 64'(wr_err), 64'd1);
    x[DW-1:0] = 16'h7FFF;
    start_valid = 1'b1; tick; start_valid = 1'b0;
    wait_done("t5_lat");
    chk("t5_y0", 64'(yv(0)), 64'd1);
    for (int c = 0; c < 20; c++) begin
      tick;
      chk("t5_hold_v", 64'(out_valid), 64'd1);
      chk("t5_hold_y", 64'(yv(0)), 64'd1);
    end
    handshake;
    tick;
    chk("t5_noqueue", 64'(busy), 64'd0);
    wr(1'b0, 0, OUT, 16'h7FFF);
    chk("t5_err_j", 64'(wr_err), 64'd1);
    wr(1'b0, IN, 0, 16'h7FFF);
    chk("t5_err_i", 64'(wr_err), 64'd1);
    x[DW-1:0] = 16'd1;
    wr_en = 1'b1; wr_sel = 1'b1; wr_in_idx = '0; wr_out_idx = '0; wr_data = 16'h4000;
    start_valid = 1'b1; relu_en = 1'b0;
    tick;
    t_acc = cyc; wr_en = 1'b0; start_valid = 1'b0;
    chk("t5_err_start", 64'(wr_err), 64'd1);
    out_ready = 1'b1;
    wait_done("t5c_lat");
    chk("t5c_y0", 64'(yv(0)), 64'd1);
    tick;
    chk("t5c_one_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // 6: reset mid-MAC, then rerun of case 2
    fill_w(16'd128);
    set_x(16'd256);
    start_run(1'b0);
    repeat (41) tick;
    rst_n = 1'b0; #1;
    chk("t6_y",     64'(|y), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ready", 64'(start_ready), 64'd1);
    chk("t6_busy",  64'(busy), 64'd0);
    chk("t6_sat",   64'(sat), 64'd0);
    tick; rst_n = 1'b1; tick;
    fill_w(16'd128);
    start_run(1'b0);
    wait_done("t6_lat");
    chk_y_all("t6_y", 16'd12800);
    handshake;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
